// File: rtl/systolic_skew_feeder_if.sv
// Operand beat channel between the operand source and the skew feeder.
// One beat carries an A column slice and a B row slice under valid/ready.
interface systolic_skew_feeder_if #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4
) ();
  logic                        s_valid;
  logic                        s_ready;
  logic [ARR_HEIGHT*WIDTH-1:0] s_a;
  logic [ARR_WIDTH*WIDTH-1:0]  s_b;

  modport master (output s_valid, output s_a, output s_b, input s_ready);
  modport slave  (input s_valid, input s_a, input s_b, output s_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skew feeder for the systolic_array tile: accepts one job of k_len beats,
// delays A lane i by i and B lane j by j extra cycles, pads with zeros,
// holds the SIMD mode for the job and pulses done once the last products
// have reached the south-east PE.
module systolic_skew_feeder #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int KW         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KW-1:0]               k_len,
  input  logic [1:0]                  simd_in,
  systolic_skew_feeder_if.slave       s_bus,
  output logic [ARR_HEIGHT*WIDTH-1:0] in_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  in_b,
  output logic [1:0]                  SIMD_control,
  output logic                        busy,
  output logic                        done
);

  // Drain must cover the longest diagonal through the array.
  localparam int DRAIN_LEN = ARR_HEIGHT + ARR_WIDTH - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [KW-1:0]   beat_cnt_r, beat_cnt_s;
  logic [DW-1:0]   drain_cnt_r, drain_cnt_s;
  logic [1:0]      simd_r, simd_s;
  logic            s_ready_r, busy_r, done_r;
  logic            take_s;

  // A beat is taken only while streaming; everything else feeds zeros.
  assign take_s = (state_r == ST_STREAM) && s_bus.s_valid;

  // Next-state, counter and mode-latch logic.
  always_comb begin
    state_s     = state_r;
    beat_cnt_s  = beat_cnt_r;
    drain_cnt_s = drain_cnt_r;
    simd_s      = simd_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (k_len != {KW{1'b0}}) begin
            state_s    = ST_STREAM;
            beat_cnt_s = k_len;
            simd_s     = simd_in;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (s_bus.s_valid) begin
          beat_cnt_s = beat_cnt_r - KW'(1);
          if (beat_cnt_r == KW'(1)) begin
            state_s     = ST_DRAIN;
            drain_cnt_s = DW'(DRAIN_LEN);
          end else begin
            state_s = ST_STREAM;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        drain_cnt_s = drain_cnt_r - DW'(1);
        if (drain_cnt_r == DW'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= {KW{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      simd_r      <= 2'b00;
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_cnt_r  <= beat_cnt_s;
      drain_cnt_r <= drain_cnt_s;
      simd_r      <= simd_s;
      s_ready_r   <= (state_s == ST_STREAM);
      busy_r      <= (state_s == ST_STREAM) || (state_s == ST_DRAIN);
      done_r      <= (state_s == ST_DONE);
    end
  end

  assign s_bus.s_ready = s_ready_r;
  assign SIMD_control  = simd_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // A lane i: chain of i+1 registers, last stage drives the west edge.
  for (genvar gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_lane
    logic [WIDTH-1:0] chain_r [gi+1];

    // Load the beat (or zero) into stage 0 and shift the rest every cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= gi; k++) chain_r[k] <= {WIDTH{1'b0}};
      end else begin
        chain_r[0] <= take_s ? s_bus.s_a[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        for (int k = 1; k <= gi; k++) chain_r[k] <= chain_r[k-1];
      end
    end

    assign in_a[gi*WIDTH +: WIDTH] = chain_r[gi];
  end

  // B lane j: chain of j+1 registers, last stage drives the north edge.
  for (genvar gj = 0; gj < ARR_WIDTH; gj++) begin : g_b_lane
    logic [WIDTH-1:0] chain_r [gj+1];

    // Load the beat (or zero) into stage 0 and shift the rest every cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= gj; k++) chain_r[k] <= {WIDTH{1'b0}};
      end else begin
        chain_r[0] <= take_s ? s_bus.s_b[gj*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        for (int k = 1; k <= gj; k++) chain_r[k] <= chain_r[k-1];
      end
    end

    assign in_b[gj*WIDTH +: WIDTH] = chain_r[gj];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (WIDTH=16, 4x4, KW=8).
module tb_systolic_skew_feeder;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [1:0]      simd_in;
  logic [H*W-1:0]  in_a;
  logic [AW*W-1:0] in_b;
  logic [1:0]      simd_ctl;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;

  systolic_skew_feeder_if #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(AW)) bus ();

  systolic_skew_feeder #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(AW), .KW(KW)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .k_len        (k_len),
    .simd_in      (simd_in),
    .s_bus        (bus.slave),
    .in_a         (in_a),
    .in_b         (in_b),
    .SIMD_control (simd_ctl),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle tf+1 after the final beat edge tf.
  task automatic drain_check(input string tag);
    chk({tag, "_ready_fall"}, bus.s_ready, 1'b0);
    for (int n = 2; n <= 9; n++) begin
      tick();
      chk({tag, "_done"}, done, (n == 8));
      chk({tag, "_busy"}, busy, (n < 8));
    end
  endtask

  logic [H*W-1:0]  ea;
  logic [AW*W-1:0] eb;
  int              acc;
  int              cyc;
  logic            hs;

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; simd_in = 2'd0;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;

    // Reset with random inputs: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); k_len = KW'($urandom); simd_in = 2'($urandom);
      bus.s_valid = 1'($urandom);
      bus.s_a = {$urandom, $urandom}; bus.s_b = {$urandom, $urandom};
      tick();
    end
    chk("rst_ready", bus.s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_simd", simd_ctl, 2'd0);
    chk("rst_in_a", in_a, 64'd0);
    chk("rst_in_b", in_b, 64'd0);
    start = 1'b0; k_len = '0; simd_in = 2'd0; bus.s_valid = 1'b0;
    bus.s_a = '0; bus.s_b = '0;
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_ready", bus.s_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Single job, k_len=1.
    start = 1'b1; k_len = 8'd1; simd_in = 2'd1;
    tick();
    start = 1'b0; simd_in = 2'd0;
    chk("j1_ready", bus.s_ready, 1'b1);
    chk("j1_busy", busy, 1'b1);
    chk("j1_simd", simd_ctl, 2'd1);
    bus.s_valid = 1'b1;
    bus.s_a = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.s_b = {16'd8, 16'd7, 16'd6, 16'd5};
    tick();
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
    for (int n = 1; n <= 9; n++) begin
      ea = '0; eb = '0;
      if (n <= 4) begin
        ea[(n-1)*W +: W] = W'(n);
        eb[(n-1)*W +: W] = W'(n + 4);
      end
      chk("j1_in_a", in_a, ea);
      chk("j1_in_b", in_b, eb);
      chk("j1_done", done, (n == 8));
      chk("j1_busy_drain", busy, (n < 8));
      if (n == 1) chk("j1_ready_fall", bus.s_ready, 1'b0);
      tick();
    end
    chk("j1_done_once", done, 1'b0);

    // Bubbles: k_len=4, valid on alternate cycles.
    start = 1'b1; k_len = 8'd4; simd_in = 2'd3;
    tick();
    start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 40) begin
      bus.s_valid = cyc[0];
      bus.s_a = {48'd0, W'(16'h10 + acc)};
      bus.s_b = {48'd0, W'(16'h20 + acc)};
      hs = bus.s_valid && bus.s_ready;
      tick();
      chk("bub_lane_a0", in_a[W-1:0], hs ? W'(16'h10 + acc) : W'(0));
      chk("bub_lane_b0", in_b[W-1:0], hs ? W'(16'h20 + acc) : W'(0));
      if (hs) acc++;
      cyc++;
    end
    chk("bub_accepted", acc, 4);
    chk("bub_cycles", cyc, 8);
    // Valid held high with junk during drain must not be taken.
    bus.s_valid = 1'b1; bus.s_a = '1; bus.s_b = '1;
    chk("bub_ready_fall", bus.s_ready, 1'b0);
    for (int n = 2; n <= 9; n++) begin
      tick();
      chk("bub_drain_a0", in_a[W-1:0], 16'd0);
      chk("bub_done", done, (n == 8));
    end
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
    tick();

    // Zero-length job.
    start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    chk("z_done", done, 1'b1);
    chk("z_busy", busy, 1'b0);
    chk("z_ready", bus.s_ready, 1'b0);
    tick();
    chk("z_done_once", done, 1'b0);
    chk("z_busy2", busy, 1'b0);
    tick();

    // Mid-job reset after 2 of 5 beats.
    start = 1'b1; k_len = 8'd5; simd_in = 2'd3;
    tick();
    start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_a = {16'd9, 16'd9, 16'd9, 16'd9};
    bus.s_b = {16'd9, 16'd9, 16'd9, 16'd9};
    tick(); tick();
    chk("mr_pre_ready", bus.s_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_in_a", in_a, 64'd0);
    chk("mr_in_b", in_b, 64'd0);
    chk("mr_ready", bus.s_ready, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_simd", simd_ctl, 2'd0);
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("mr_no_done", done, 1'b0);
      chk("mr_idle_ready", bus.s_ready, 1'b0);
    end
    start = 1'b1; k_len = 8'd2; simd_in = 2'd2;
    tick();
    start = 1'b0; simd_in = 2'd0;
    chk("mr2_simd", simd_ctl, 2'd2);
    bus.s_valid = 1'b1;
    bus.s_a = {16'd0, 16'd0, 16'd0, 16'd7};
    bus.s_b = {16'd0, 16'd0, 16'd0, 16'd3};
    tick();
    chk("mr2_a0", in_a[W-1:0], 16'd7);
    tick();
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
    drain_check("mr2");
    chk("mr2_simd_hold", simd_ctl, 2'd2);
    tick();

    // Start pulsed during STREAM and DRAIN with another k_len is ignored.
    start = 1'b1; k_len = 8'd3; simd_in = 2'd1;
    tick();
    k_len = 8'd7; simd_in = 2'd3;
    bus.s_valid = 1'b1;
    bus.s_a = {16'd1, 16'd1, 16'd1, 16'd1};
    bus.s_b = {16'd1, 16'd1, 16'd1, 16'd1};
    tick(); tick();
    chk("ig_ready_mid", bus.s_ready, 1'b1);
    tick();
    chk("ig_simd", simd_ctl, 2'd1);
    chk("ig_ready_fall", bus.s_ready, 1'b0);
    for (int n = 2; n <= 9; n++) begin
      if (n == 7) start = 1'b0;
      tick();
      chk("ig_done", done, (n == 8));
      chk("ig_busy", busy, (n < 8));
    end
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
    tick();
    chk("ig_idle_ready", bus.s_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream stage of the `systolic_array` tile. It accepts one job of `k_len` operand beats over a valid/ready handshake. Each beat carries one column slice of A (`ARR_HEIGHT` elements) and one row slice of B (`ARR_WIDTH` elements). The feeder applies the diagonal skew the array needs: row i is delayed i extra cycles and column j is delayed j extra cycles. It pads with zeros, holds `SIMD_control` stable for the whole job, and pulses `done` once the last products have reached the south-east PE.

## Interface
- `WIDTH`, 16, element width in bits
- `ARR_HEIGHT`, 4, array rows (A lanes)
- `ARR_WIDTH`, 4, array columns (B lanes)
- `KW`, 8, width of `k_len`

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock; all state cleared while low
- `start`  in  1  job request, sampled only in IDLE
- `k_len`  in  KW  beats in the job, sampled with `start`
- `simd_in`  in  2  SIMD mode, sampled with `start`
- `s_valid`  in  1  beat valid
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`
- `s_a`  in  ARR_HEIGHT*WIDTH  A slice; element i at bits [(i+1)*WIDTH-1 : i*WIDTH]
- `s_b`  in  ARR_WIDTH*WIDTH  B slice; element j at bits [(j+1)*WIDTH-1 : j*WIDTH]
- `in_a`  out  ARR_HEIGHT*WIDTH  skewed A, drives the array's west edge
- `in_b`  out  ARR_WIDTH*WIDTH  skewed B, drives the array's north edge
- `SIMD_control`  out  2  held mode for the array
- `busy`  out  1  high in STREAM and DRAIN
- `done`  out  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE -> STREAM on `start` with `k_len` != 0. On that edge, latch `k_len` into a beat counter and `simd_in` into `SIMD_control`.
- IDLE -> DONE on `start` with `k_len` == 0. No beats are taken.
- STREAM:
  - `s_ready` = 1.
  - Each accepted beat decrements the beat counter.
  - A cycle without `s_valid` injects a zero beat (bubble). Zeros on A and B together add nothing to any accumulator, so alignment is preserved.
  - The edge that accepts the final beat moves the FSM to DRAIN and loads the drain counter with `ARR_HEIGHT+ARR_WIDTH-1`.
- DRAIN:
  - `s_ready` = 0 and zeros are injected.
  - The drain counter decrements each cycle. When it is 1, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. `k_len` and `simd_in` are not re-sampled mid-job.
- Skew lanes: A lane i is a shift chain of i+1 registers and B lane j is a chain of j+1 registers. Stage 0 loads the beat, or zero for a bubble or drain cycle. Later stages shift every cycle, with no stall.
- In IDLE and DONE, stage 0 loads zero, so the array sees zeros between jobs.
- `SIMD_control` holds its latched value until the next accepted `start`.

## Timing
- Reset values: `s_ready`=0, `busy`=0, `done`=0, `SIMD_control`=0, `in_a`=0, `in_b`=0, all lane registers 0, FSM in IDLE, counters 0.
- Reset asserted mid-job: the job is aborted immediately (asynchronous). After release the block is in IDLE; no `done` is produced for the aborted job.
- `start` sampled at edge t0: `s_ready`=1 and `busy`=1 from cycle t0+1.
- Beat accepted at edge t:
  - A element i appears on `in_a` lane i during cycle t+1+i.
  - B element j appears on `in_b` lane j during cycle t+1+j.
- Final beat accepted at edge tf:
  - `s_ready` falls in cycle tf+1.
  - `done` is high in cycle tf+ARR_HEIGHT+ARR_WIDTH; `busy` is low in that same cycle.
  - The array's `out_c` is final at the next edge.
- `k_len`=0 sampled at edge t0: `done` is high in cycle t0+1 and `busy` never rises.
- Back-to-back jobs: the earliest next `start` is sampled at the edge after `done`, since IDLE is entered then. Lanes are already zero, so there is no cross-job contamination.

## Test plan
- Reset: hold `reset`=0 with random inputs -> all outputs 0. Release -> IDLE; `s_ready`=0 until `start`.
- Single job, H=W=4, `k_len`=1, `s_a`={4,3,2,1}, `s_b`={8,7,6,5}, accepted at edge t:
  - `in_a` lane 0 shows 1 at cycle t+1; lane 3 shows 4 at cycle t+4; zeros otherwise.
  - `in_b` lane 3 shows 8 at cycle t+4.
  - `done` pulses at cycle t+8.
- Bubbles: `k_len`=4 with `s_valid` low on alternate cycles -> exactly 4 beats accepted, zero beats in the gaps. With the real `systolic_array` downstream, `out_c` equals the reference A×B.
- Zero length: `start` with `k_len`=0 -> `done` the next cycle, `busy` stays 0, no `s_ready`.
- Mid-job reset: assert `reset` after 2 of 5 beats -> outputs 0 immediately. A new job with `simd_in`=2 then runs cleanly: `SIMD_control`=2 and the correct `done` timing.
- Ignored start: pulse `start` during STREAM and DRAIN with a different `k_len` -> no effect on the beat count or `done` timing.
